// File: rtl/ifu_pkg.sv
//------------------------------------------------------------------------------
// Module : ifu_pkg
// Brief  : Shared constants and state encoding for the instruction fetch unit.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ifu_pkg;

    localparam int          AXI_ADDR_W         = 32;
    localparam int          AXI_DATA_W         = 32;
    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP           = 32'h0000_0013;
    localparam logic [1:0]  AXI_RESP_OKAY      = 2'b00;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } ifu_state_t;

endpackage

`default_nettype wire

// File: rtl/ifu_pc_gen.sv
//------------------------------------------------------------------------------
// Module : ifu_pc_gen
// Brief  : PC and kill-flag holder; next PC priority redirect > +4 > hold.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifu_pc_gen
    import ifu_pkg::*;
#(
    parameter int                ADDR_W     = AXI_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    input  logic              kill_set,
    input  logic              kill_clr,
    output logic [ADDR_W-1:0] pc_next,
    output logic              kill
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              kill_q, kill_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (advance) begin
            pc_d = pc_q + ADDR_W'(4);
        end

        // Consuming the stale beat always ends the kill window.
        kill_d = kill_q;
        if (kill_clr) begin
            kill_d = 1'b0;
        end else if (kill_set) begin
            kill_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_ADDR;
            kill_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            kill_q <= kill_d;
        end
    end

    assign pc_next = pc_d;
    assign kill    = kill_q;

endmodule

`default_nettype wire

// File: rtl/ifu_axi_fetch.sv
//------------------------------------------------------------------------------
// Module : ifu_axi_fetch
// Brief  : AXI-lite instruction fetch master with redirect/kill handling.
//          Optional performance counters under IFU_PERF_CNT_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifu_axi_fetch
    import ifu_pkg::*;
#(
    parameter int                ADDR_W     = AXI_ADDR_W,
    parameter int                DATA_W     = AXI_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt
`endif
);

    ifu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_err_q, inst_err_d;
    logic              inst_valid_q, inst_valid_d;

    logic              ar_hs, r_hs, d_hs;
    logic              advance, kill_set, kill_clr, capture;
    logic              kill;
    logic [ADDR_W-1:0] pc_next;

    assign ar_hs = arvalid_q & arready;
    assign r_hs  = rready_q & rvalid;
    assign d_hs  = inst_valid_q & inst_ready;

    ifu_pc_gen #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (RESET_ADDR)
    ) u_pc_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .kill_set       (kill_set),
        .kill_clr       (kill_clr),
        .pc_next        (pc_next),
        .kill           (kill)
    );

    always_comb begin
        state_d  = state_q;
        advance  = 1'b0;
        kill_set = 1'b0;
        kill_clr = 1'b0;
        capture  = 1'b0;
        case (state_q)
            REQ: begin
                if (ar_hs) begin
                    state_d = RESP;
                end
                // Once arvalid is up the address is committed, so the redirect
                // must wait for the stale beat to be drained.
                if (redirect_valid && arvalid_q) begin
                    kill_set = 1'b1;
                end
            end
            RESP: begin
                if (r_hs) begin
                    kill_clr = 1'b1;
                    if (kill || redirect_valid) begin
                        state_d = REQ;
                    end else begin
                        state_d = HOLD;
                        capture = 1'b1;
                    end
                end else if (redirect_valid) begin
                    kill_set = 1'b1;
                end
            end
            HOLD: begin
                advance = d_hs;
                if (d_hs || redirect_valid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_comb begin
        arvalid_d    = (state_d == REQ);
        rready_d     = (state_d == RESP);
        inst_valid_d = (state_d == HOLD);

        // Reload the request address only when no AR is currently offered.
        araddr_d = araddr_q;
        if ((state_d == REQ) && !((state_q == REQ) && arvalid_q)) begin
            araddr_d = pc_next;
        end

        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;
        if (capture) begin
            inst_d     = rdata;
            inst_pc_d  = araddr_q;
            inst_err_d = (rresp != AXI_RESP_OKAY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            araddr_q     <= RESET_ADDR;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_q       <= DATA_W'(INST_NOP);
            inst_pc_q    <= RESET_ADDR;
            inst_err_q   <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_err_q   <= inst_err_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_err   = inst_err_q;
    assign inst_valid = inst_valid_q;

`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [63:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (d_hs) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 64'd1;
        end
        if ((state_q == REQ) || (state_q == RESP)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt_q <= 64'd0;
            perf_stall_cnt_q <= 64'd0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_axi_fetch.sv
//------------------------------------------------------------------------------
// Module : tb_ifu_axi_fetch
// Brief  : Self-checking bench for ifu_axi_fetch with an AXI-lite slave model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ifu_axi_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    always #5 clk = ~clk;

    ifu_axi_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int          passes = 0;
    int          fails  = 0;
    int          total  = 0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] err_pc = 32'h0000_0001;
    bit          rand_err = 1'b0;
    bit          rand_lat = 1'b0;
    int          ar_lat_cfg = 1;
    int          r_lat_cfg  = 2;
    bit          ar_pend = 1'b0;
    logic [31:0] ar_pend_addr = 32'h0;

    // Instruction memory contents seen through the slave.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h0000_0297;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        if (a == err_pc || (rand_err && w[2:0] == 3'b000)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // AXI-lite slave: one read at a time, configurable or random latency.
    initial begin
        int          ph;
        int          cnt;
        logic [31:0] a;
        ph = 0; cnt = 0; a = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                ph = 0; arready = 1'b0; rvalid = 1'b0;
            end else begin
                case (ph)
                    0: if (arvalid) begin
                        a   = araddr;
                        cnt = rand_lat ? int'($urandom_range(0, 2)) : ar_lat_cfg;
                        if (cnt == 0) begin arready = 1'b1; ph = 2; end
                        else ph = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin arready = 1'b1; ph = 2; end
                    end
                    2: begin
                        arready = 1'b0;
                        cnt = rand_lat ? int'($urandom_range(0, 2)) : r_lat_cfg;
                        if (cnt == 0) begin
                            rvalid = 1'b1; rdata = mem_word(a); rresp = mem_resp(a); ph = 4;
                        end else ph = 3;
                    end
                    3: begin
                        cnt--;
                        if (cnt == 0) begin
                            rvalid = 1'b1; rdata = mem_word(a); rresp = mem_resp(a); ph = 4;
                        end
                    end
                    default: begin
                        rvalid = 1'b0; rdata = 32'hDEAD_BEEF; rresp = 2'b00; ph = 0;
                    end
                endcase
            end
        end
    end

    // One clock of decode-side stimulus; model advances on handshakes/redirects.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(negedge clk);
        if (ar_pend) begin
            check("ar_stable_valid", arvalid, 1);
            check("ar_stable_addr", araddr, ar_pend_addr);
        end
        ar_pend      = arvalid && !arready;
        ar_pend_addr = araddr;
        if (inst_valid === 1'b1) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst", inst, mem_word(exp_pc));
            check("inst_err", inst_err, (mem_resp(exp_pc) != 2'b00));
            if (rdy) exp_pc = exp_pc + 32'd4;
        end
        if (redir) exp_pc = rpc;
        @(posedge clk); #1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (inst_valid !== 1'b1 && n < maxc) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        check("wait_valid_timeout", inst_valid, 1);
    endtask

    task automatic wait_ar(input int maxc);
        int n = 0;
        bit saw_valid = 1'b0;
        while (arvalid !== 1'b1 && n < maxc) begin
            if (inst_valid === 1'b1) saw_valid = 1'b1;
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        check("wait_ar_timeout", arvalid, 1);
        check("no_inst_before_ar", saw_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit rdy, rd;
        logic [31:0] rpc;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_araddr", araddr, RST_PC);
        check("rst_inst", inst, NOP);
        check("rst_inst_pc", inst_pc, RST_PC);
        check("rst_inst_err", inst_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("arvalid_before_edge", arvalid, 0);
        @(posedge clk); #1;
        check("first_arvalid", arvalid, 1);
        check("first_araddr", araddr, RST_PC);

        // First fetch, then decode stalls for 5 cycles
        wait_valid(20);
        check("first_inst", inst, 32'h0000_0297);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            check("stall_no_arvalid", arvalid, 0);
            check("stall_inst_valid", inst_valid, 1);
        end
        step(1'b1, 1'b0, 32'h0);
        wait_ar(10);
        check("seq_araddr", araddr, 32'h8000_0004);

        // Redirect while the fetch for 0x8000_0008 is in RESP
        wait_valid(20);
        step(1'b1, 1'b0, 32'h0);
        n = 0;
        while (!(rready === 1'b1 && araddr === 32'h8000_0008) && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        check("reach_resp_8", rready, 1);
        step(1'b0, 1'b1, 32'h8000_0100);
        wait_ar(20);
        check("redir_resp_araddr", araddr, 32'h8000_0100);

        // Redirect in HOLD coincident with inst_ready
        err_pc = 32'h8000_0204;
        wait_valid(20);
        step(1'b1, 1'b1, 32'h8000_0200);
        wait_ar(10);
        check("redir_hold_araddr", araddr, 32'h8000_0200);

        // Error response, then a clean fetch
        wait_valid(20);
        step(1'b1, 1'b0, 32'h0);
        wait_valid(20);
        check("err_inst_pc", inst_pc, 32'h8000_0204);
        check("err_flag", inst_err, 1);
        step(1'b1, 1'b0, 32'h0);
        wait_valid(20);
        check("clean_after_err", inst_err, 0);
        step(1'b1, 1'b0, 32'h0);

        // Redirect while AR offered, to the top of the address space (wrap)
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid(30);
        check("wrap_top_pc", inst_pc, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        wait_valid(30);
        check("wrap_zero_pc", inst_pc, 32'h0000_0000);
        step(1'b1, 1'b0, 32'h0);

        // Randomized traffic against the model
        err_pc   = 32'h0000_0001;
        rand_err = 1'b1;
        rand_lat = 1'b1;
        for (int i = 0; i < 800; i++) begin
            rdy = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                              : RST_PC + ($urandom_range(0, 255) << 2);
            step(rdy, rd, rpc);
        end

        // Asynchronous reset in the middle of RESP
        rand_lat = 1'b0;
        n = 0;
        while (rready !== 1'b1 && n < 50) begin
            step(1'b1, 1'b0, 32'h0);
            n++;
        end
        check("reach_resp_for_reset", rready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_arvalid", arvalid, 0);
        check("async_rready", rready, 0);
        check("async_inst_valid", inst_valid, 0);
        exp_pc  = RST_PC;
        ar_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ar(10);
        check("restart_araddr", araddr, RST_PC);
        wait_valid(20);
        check("restart_inst", inst, 32'h0000_0297);
        step(1'b1, 1'b0, 32'h0);
        wait_ar(10);
        check("restart_next_araddr", araddr, 32'h8000_0004);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
